// File: rtl/graph_pkg.sv
// Shared definitions for the graph fetch engine: FSM states and vertex record word offsets.
package graph_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    HWAIT = 3'd2,
    FETCH = 3'd3,
    DRAIN = 3'd4
  } state_t;

  // Word offsets inside a vertex record relative to its base address
  localparam int HDR_OFS  = 0;
  localparam int FEAT_OFS = 1;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign empty    = (count == '0);

endmodule

// File: rtl/graph_fetch_engine.sv
// Fetches a vertex record (header, DIM features, N neighbour indices) over an in-order read port.
// Define GRAPH_FETCH_CLAMP_EN to clamp N to MAX_NEIGH and flag truncation on trunc_out.
module graph_fetch_engine
  import graph_pkg::*;
#(
  parameter int DIM      = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_OUT  = 4,
  parameter int NQ_DEPTH = 8
`ifdef GRAPH_FETCH_CLAMP_EN
  ,
  parameter int MAX_NEIGH = 16
`endif
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         v_valid_in,
  input  logic [ADDR_W-1:0]            v_addr_in,
  output logic                         v_ready_out,
  output logic                         mem_req_valid_out,
  output logic [ADDR_W-1:0]            mem_req_addr_out,
  input  logic                         mem_req_ready_in,
  input  logic                         mem_resp_valid_in,
  input  logic [DATA_W-1:0]            mem_resp_data_in,
  output logic [DIM-1:0][DATA_W-1:0]   data_out,
  output logic                         data_valid_out,
  output logic [DATA_W-1:0]            neigh_out,
  output logic                         neigh_valid_out,
  output logic                         neigh_last_out,
  input  logic                         neigh_ready_in,
  output logic                         busy_out,
  output logic                         trunc_out
);

  localparam int OUT_W = $clog2(MAX_OUT + 1);
  localparam int NQ_W  = $clog2(NQ_DEPTH + 1);
  localparam int SUM_W = NQ_W + 1;
  localparam int CNT_W = DATA_W + 2;

  state_t              state;
  logic [ADDR_W-1:0]   base;
  logic [CNT_W-1:0]    idx;
  logic [CNT_W-1:0]    last_ofs;
  logic [CNT_W-1:0]    rsp_cnt;
  logic [OUT_W-1:0]    out_cnt;
  logic [NQ_W-1:0]     nout_cnt;
  logic [NQ_W-1:0]     q_count;
  logic                q_empty;
  logic [DATA_W:0]     q_dout;
  logic [DATA_W-1:0]   n_eff;

  logic slot_free, idx_neigh, room_out, room_q;
  logic load_hdr, load_fetch, load_neigh, load;
  logic rsp_take, rsp_hdr, rsp_feat, rsp_neigh, last_beat, q_pop;

  // The request register counts as outstanding from the moment it is loaded,
  // so the limits below also cover a request still waiting for ready.
  assign slot_free  = !mem_req_valid_out || mem_req_ready_in;
  assign idx_neigh  = idx > CNT_W'(DIM);
  assign room_out   = out_cnt < OUT_W'(MAX_OUT);
  assign room_q     = (SUM_W'(nout_cnt) + SUM_W'(q_count)) < SUM_W'(NQ_DEPTH);
  assign load_hdr   = (state == HDR) && slot_free;
  assign load_fetch = (state == FETCH) && slot_free && room_out && (!idx_neigh || room_q);
  assign load_neigh = load_fetch && idx_neigh;
  assign load       = load_hdr || load_fetch;

  assign rsp_take  = mem_resp_valid_in && (out_cnt != '0) && (state != IDLE);
  assign rsp_hdr   = rsp_take && (state == HWAIT);
  assign rsp_feat  = rsp_take && (state != HWAIT) && (rsp_cnt < CNT_W'(DIM));
  assign rsp_neigh = rsp_take && (state != HWAIT) && !(rsp_cnt < CNT_W'(DIM));
  assign last_beat = (rsp_cnt == last_ofs - CNT_W'(1));
  assign q_pop     = !q_empty && neigh_ready_in;

`ifdef GRAPH_FETCH_CLAMP_EN
  logic clamp_hit;
  logic trunc;
  assign clamp_hit = mem_resp_data_in > DATA_W'(MAX_NEIGH);
  assign n_eff     = clamp_hit ? DATA_W'(MAX_NEIGH) : mem_resp_data_in;
  assign trunc_out = trunc;
`else
  assign n_eff     = mem_resp_data_in;
  assign trunc_out = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state             <= IDLE;
      idx               <= '0;
      last_ofs          <= '0;
      rsp_cnt           <= '0;
      out_cnt           <= '0;
      nout_cnt          <= '0;
      mem_req_valid_out <= 1'b0;
      data_valid_out    <= 1'b0;
      data_out          <= '0;
`ifdef GRAPH_FETCH_CLAMP_EN
      trunc             <= 1'b0;
`endif
    end else begin
      out_cnt        <= out_cnt + OUT_W'(load) - OUT_W'(rsp_take);
      nout_cnt       <= nout_cnt + NQ_W'(load_neigh) - NQ_W'(rsp_neigh);
      data_valid_out <= rsp_feat && (rsp_cnt == CNT_W'(DIM - 1));

      if (load) begin
        mem_req_valid_out <= 1'b1;
        mem_req_addr_out  <= base + ADDR_W'(load_hdr ? CNT_W'(HDR_OFS) : idx);
      end else if (mem_req_ready_in) begin
        mem_req_valid_out <= 1'b0;
      end

      if (rsp_take && (state != HWAIT)) rsp_cnt <= rsp_cnt + CNT_W'(1);
      if (rsp_feat) begin
        for (int k = 0; k < DIM; k++) begin
          if (rsp_cnt == CNT_W'(k)) data_out[k] <= mem_resp_data_in;
        end
      end

      case (state)
        IDLE: begin
          if (v_valid_in) begin
            base  <= v_addr_in;
            state <= HDR;
          end
        end
        HDR: begin
          if (load_hdr) state <= HWAIT;
        end
        HWAIT: begin
          if (rsp_hdr) begin
            last_ofs <= CNT_W'(DIM) + CNT_W'(n_eff);
            idx      <= CNT_W'(FEAT_OFS);
            rsp_cnt  <= '0;
`ifdef GRAPH_FETCH_CLAMP_EN
            trunc    <= clamp_hit;
`endif
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (load_fetch) begin
            idx <= idx + CNT_W'(1);
            if (idx == last_ofs) state <= DRAIN;
          end
        end
        DRAIN: begin
          if ((out_cnt == '0) && q_empty && !mem_req_valid_out) begin
`ifdef GRAPH_FETCH_CLAMP_EN
            trunc <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign v_ready_out = (state == IDLE);
  assign busy_out    = (state != IDLE);

  sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (NQ_DEPTH)
  ) u_nq (
    .clk       (clk_in),
    .rst       (rst_in),
    .push      (rsp_neigh),
    .push_data ({last_beat, mem_resp_data_in}),
    .pop       (q_pop),
    .pop_data  (q_dout),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign neigh_valid_out = !q_empty;
  assign neigh_out       = q_dout[DATA_W-1:0];
  assign neigh_last_out  = !q_empty && q_dout[DATA_W];

endmodule

// File: doc/graph_fetch_engine.md
GRAPH_FETCH_ENGINE -- requirements
Module: graph_fetch_engine

Interface
REQ-001 SHALL have parameter DIM, default 2: feature words per vertex (>=1).
REQ-002 SHALL have parameter ADDR_W, default 32: memory word-address width.
REQ-003 SHALL have parameter DATA_W, default 32: memory/feature/neighbour word width.
REQ-004 SHALL have parameter MAX_OUT, default 4: maximum outstanding memory reads (power of two).
REQ-005 SHALL have parameter NQ_DEPTH, default 8: neighbour output queue depth (power of two, >= MAX_OUT).
REQ-006 SHALL have port clk_in, input, 1: single clock; one clock, all logic on rising edge.
REQ-007 SHALL have port rst_in, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have ports v_valid_in (in, 1), v_addr_in (in, ADDR_W), v_ready_out (out, 1): vertex request handshake.
REQ-009 SHALL have ports mem_req_valid_out (out, 1), mem_req_addr_out (out, ADDR_W), mem_req_ready_in (in, 1): read request channel.
REQ-010 SHALL have ports mem_resp_valid_in (in, 1), mem_resp_data_in (in, DATA_W): in-order read responses, no backpressure.
REQ-011 SHALL have ports data_out (out, DIM x DATA_W array), data_valid_out (out, 1): feature vector, one-cycle pulse.
REQ-012 SHALL have ports neigh_out (out, DATA_W), neigh_valid_out (out, 1), neigh_last_out (out, 1), neigh_ready_in (in, 1): neighbour stream.
REQ-013 SHALL have ports busy_out (out, 1) and trunc_out (out, 1).

Function
REQ-014 Memory layout at v_addr: word 0 = neighbour count N; words 1..DIM = features; words DIM+1..DIM+N = neighbour row indices.
REQ-015 v_ready_out SHALL be 1 only in IDLE; request accepted on v_valid_in & v_ready_out, v_addr_in latched.
REQ-016 FSM states: IDLE -> HDR (issue read of word 0) -> HWAIT (await header) -> FETCH (issue words 1..DIM+N) -> DRAIN (outstanding reads and neighbour queue empty) -> IDLE.
REQ-017 A request fires on mem_req_valid_out & mem_req_ready_in; mem_req_addr_out SHALL hold stable while valid and not ready.
REQ-018 Reads issue in ascending address order, at most one per cycle; addresses wrap modulo 2^ADDR_W.
REQ-019 Issue SHALL stall when outstanding count == MAX_OUT, or, for neighbour words, when outstanding neighbour reads + queue occupancy == NQ_DEPTH; responses never drop.
REQ-020 Outstanding counter SHALL handle simultaneous issue and response (net unchanged).
REQ-021 Feature responses fill data_out[0..DIM-1] in order; data_valid_out pulses exactly one cycle after the DIM-th feature response; data_out holds until next vertex's first feature write.
REQ-022 Neighbour responses enter the queue; neigh_valid_out = queue non-empty; pop on neigh_valid_out & neigh_ready_in; neigh_last_out = 1 on the N-th neighbour.
REQ-023 N = 0: no neighbour reads, no neighbour beats; FSM reaches IDLE after data_valid_out.
REQ-024 busy_out = 1 in every state except IDLE.
REQ-025 Responses arriving in IDLE SHALL be ignored.

Reset
REQ-026 On rst_in: FSM to IDLE, counters and queue cleared; v_ready_out=1, mem_req_valid_out=0, data_valid_out=0, neigh_valid_out=0, neigh_last_out=0, busy_out=0, trunc_out=0, data_out all zero.
REQ-027 Reset mid-operation SHALL abandon the vertex; no further outputs for it; subsequent vertex behaves normally (system resets memory concurrently).

Configuration
REQ-028 Macro GRAPH_FETCH_CLAMP_EN: when defined, parameter MAX_NEIGH (default 16) exists; N > MAX_NEIGH is clamped to MAX_NEIGH and trunc_out = 1 from header receipt until return to IDLE.
REQ-029 Without GRAPH_FETCH_CLAMP_EN: full N (DATA_W bits) fetched, trunc_out tied 0.

Structure
REQ-030 Shared package graph_pkg SHALL hold the FSM state enum and header/feature offset constants (HDR_OFS=0, FEAT_OFS=1).
REQ-031 Neighbour queue SHALL be sub-module sync_fifo (DATA_W+1 wide incl. last flag, depth NQ_DEPTH).

Verification
REQ-032 DIM=2, addr 0x100, mem[0x100..0x104]={2,0xA,0xB,0x7,0x9}, always ready -> reads 0x100..0x104, data_out={0xA,0xB}, neigh 0x7, 0x9 (last on 0x9).
REQ-033 N=0 at addr 0x40 -> exactly 3 reads, one data_valid_out pulse, no neigh_valid_out, v_ready_out back high.
REQ-034 N=12, neigh_ready_in=0 -> issue stalls with outstanding+queue=8; releasing ready -> all 12 delivered in order, one last.
REQ-035 mem_req_ready_in toggling 1/0, response latency 5 -> outstanding never >4, address held while stalled, correct data.
REQ-036 rst_in asserted 1 cycle during FETCH -> all outputs reset values next cycle; next vertex fetched correctly.
REQ-037 GRAPH_FETCH_CLAMP_EN, MAX_NEIGH=16, N=20 -> 16 neighbour reads, last on 16th, trunc_out=1 until IDLE.
